// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline-stage register.
// The state enum decodes the two entry valids for debug visibility and assertions.
package pipe_types;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_e;

   function automatic pipe_state_e decode_state(input logic main_v, input logic skid_v);
      if (skid_v)      return PS_TWO;
      else if (main_v) return PS_ONE;
      else             return PS_EMPTY;
   endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: two-entry skid buffer with a flop-driven in_ready,
// flush with NOP bubble insertion and a saturating back-pressure stall counter.
module pipe_stage_elastic
   import pipe_types::*;
#(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   NOP_VALUE = '0,
   parameter int                 CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 clr_stats,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   logic [WIDTH-1:0]     main_q, main_d;
   logic [WIDTH-1:0]     skid_q, skid_d;
   logic                 main_v, main_v_d;
   logic                 skid_v, skid_v_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   pipe_state_e          state;
   logic                 accept;
   logic                 drain;

   assign state        = decode_state(main_v, skid_v);
   assign accept       = in_valid & in_ready;
   assign drain        = out_valid & out_ready;

   assign out_valid    = main_v;
   assign in_ready     = ~skid_v;
   assign out_data     = main_v ? main_q : NOP_VALUE;
   assign occupancy    = {1'b0, main_v} + {1'b0, skid_v};
   assign stall_cycles = stall_q;

   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v;
      skid_v_d = skid_v;
      if (flush) begin
         // Data flops keep stale contents; out_data is masked while invalid.
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else begin
         unique case (state)
            PS_EMPTY: begin
               if (accept) begin
                  main_v_d = 1'b1;
                  main_d   = in_data;
               end
            end
            PS_ONE: begin
               if (accept && drain) begin
                  main_d = in_data;
               end else if (accept) begin
                  skid_v_d = 1'b1;
                  skid_d   = in_data;
               end else if (drain) begin
                  main_v_d = 1'b0;
               end
            end
            PS_TWO: begin
               if (drain) begin
                  main_d   = skid_q;
                  skid_v_d = 1'b0;
               end
            end
            default: begin
               main_v_d = 1'b0;
               skid_v_d = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (clr_stats) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         stall_q <= '0;
      end else begin
         main_q  <= main_d;
         skid_q  <= skid_d;
         main_v  <= main_v_d;
         skid_v  <= skid_v_d;
         stall_q <= stall_d;
      end
   end

`ifndef SYNTHESIS
   a_skid_needs_main: assert property (@(posedge clk) disable iff (rst) skid_v |-> main_v);
   a_no_accept_full:  assert property (@(posedge clk) disable iff (rst) skid_v |-> !accept);
   a_stall_monotonic: assert property (@(posedge clk) disable iff (rst)
                                       !clr_stats |=> stall_q >= $past(stall_q));
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic: streaming, stall, flush,
// counter saturation/clear and asynchronous reset.
module tb_pipe_stage_elastic;

   localparam int               WIDTH = 32;
   localparam int               CW    = 4;
   localparam logic [WIDTH-1:0] NOP   = 32'hDEAD_BEEF;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             clr_stats;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;
   logic [CW-1:0]    stall_cycles;

   int checks   = 0;
   int failures = 0;

   pipe_stage_elastic #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // Drive at the falling edge, then advance to just past the next rising edge.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input logic clr);
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = ordy; flush = fl; clr_stats = clr;
      @(posedge clk);
      #1;
      $display("t=%0t in_v=%0b in_d=%h ordy=%0b fl=%0b clr=%0b -> out_v=%0b out_d=%h occ=%0d rdy=%0b stall=%0d",
               $time, v, d, ordy, fl, clr, out_valid, out_data, occupancy, in_ready, stall_cycles);
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 0; clr_stats = 0; in_valid = 0; in_data = '0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL reset_out_data got %h exp %h", out_data, NOP); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
      checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single;
      drive(1, 32'h11, 1, 0, 0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'h11) begin failures++; $display("FAIL single_data got %h exp 00000011", out_data); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL single_occ got %0d exp 1", occupancy); end
      drive(0, 32'h0, 1, 0, 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got %b exp 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL single_nop got %h exp %h", out_data, NOP); end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 8; i++) begin
         drive(1, WIDTH'(i), 1, 0, 0);
         checks++; if (out_data !== WIDTH'(i) || out_valid !== 1'b1)
            begin failures++; $display("FAIL b2b_data[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_data, WIDTH'(i)); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      end
      drive(0, 32'h0, 1, 0, 0);
      checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_occ got %0d exp 0", occupancy); end
      checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL b2b_stall got %0d exp 0", stall_cycles); end
   endtask

   task automatic test_stall;
      drive(1, 32'hA, 0, 0, 0);
      drive(1, 32'hB, 0, 0, 0);
      checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL stall_occ got %0d exp 2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got %b exp 0", in_ready); end
      drive(1, 32'hC, 0, 0, 0);
      drive(1, 32'hC, 0, 0, 0);
      checks++; if (out_data !== 32'hA) begin failures++; $display("FAIL stall_hold got %h exp 0000000a", out_data); end
      checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL stall_occ2 got %0d exp 2", occupancy); end
      drive(1, 32'hC, 1, 0, 0);
      checks++; if (out_data !== 32'hB) begin failures++; $display("FAIL stall_out_b got %h exp 0000000b", out_data); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_reopen got %b exp 1", in_ready); end
      drive(1, 32'hC, 1, 0, 0);
      checks++; if (out_data !== 32'hC) begin failures++; $display("FAIL stall_out_c got %h exp 0000000c", out_data); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stall_occ3 got %0d exp 1", occupancy); end
      drive(0, 32'h0, 1, 0, 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got %b exp 0", out_valid); end
      checks++; if (stall_cycles !== 4'd3) begin failures++; $display("FAIL stall_count got %0d exp 3", stall_cycles); end
   endtask

   task automatic test_flush;
      drive(1, 32'hA, 0, 0, 0);
      drive(1, 32'hB, 0, 0, 0);
      drive(1, 32'hC, 0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL flush_data got %h exp %h", out_data, NOP); end
      checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %b exp 1", in_ready); end
      drive(0, 32'h0, 1, 0, 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c got v=%b %h exp 0", out_valid, out_data); end
      // Input offered while in_ready=1 during a flush is still dropped.
      drive(1, 32'h55, 1, 0, 0);
      drive(1, 32'h66, 1, 1, 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got v=%b %h exp 0", out_valid, out_data); end
      drive(0, 32'h0, 1, 0, 0);
   endtask

   task automatic test_saturate;
      drive(0, 32'h0, 1, 0, 1);
      checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL sat_clear0 got %0d exp 0", stall_cycles); end
      drive(1, 32'h77, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         drive(0, 32'h0, 0, 0, 0);
         if (k == 14) begin
            checks++; if (stall_cycles !== 4'd14) begin failures++; $display("FAIL sat_mid got %0d exp 14", stall_cycles); end
         end
      end
      checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_final got %0d exp 15", stall_cycles); end
      drive(0, 32'h0, 0, 0, 1);
      checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL sat_clr got %0d exp 0", stall_cycles); end
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL sat_restart got %0d exp 1", stall_cycles); end
   endtask

   task automatic test_async_reset;
      drive(1, 32'h88, 0, 0, 0);
      checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL arst_pre_occ got %0d exp 2", occupancy); end
      @(negedge clk);
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== NOP)
         begin failures++; $display("FAIL arst_out got v=%b %h exp v=0 %h", out_valid, out_data, NOP); end
      checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1)
         begin failures++; $display("FAIL arst_occ got occ=%0d rdy=%b exp 0 1", occupancy, in_ready); end
      checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL arst_stall got %0d exp 0", stall_cycles); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 32'h99, 1, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h99)
         begin failures++; $display("FAIL arst_first got v=%b %h exp v=1 00000099", out_valid, out_data); end
      drive(0, 32'h0, 1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_flush();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-stage register: the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB load/reset register banks. Carries one packed payload bundle (control word, instruction, PC, operands, concatenated by the instantiating stage) with a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. Adds synchronous flush with NOP bubble insertion and a saturating back-pressure stall counter for performance analysis.

## Interface
- `WIDTH`, 32: payload width in bits; set by the instantiating stage from `$bits` of its bundle.
- `NOP_VALUE`, '0: payload driven on `out_data` whenever `out_valid`=0; an all-zero control word means no register or memory writes.
- `CNT_WIDTH`, 32: width of `stall_cycles`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous squash of all held entries.
- `clr_stats`  in  1  synchronous clear of `stall_cycles`.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept; driven directly from a flop.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  head entry, or `NOP_VALUE` when not valid.
- `occupancy`  out  2  number of held entries, 0 to 2.
- `stall_cycles`  out  CNT_WIDTH  count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Definitions:
  - `accept` = `in_valid` & `in_ready`.
  - `drain` = `out_valid` & `out_ready`.
- Storage:
  - main entry: `main_q`, `main_v`.
  - skid entry: `skid_q`, `skid_v`.
- State, encoded by valids: `PS_EMPTY` (0 entries), `PS_ONE` (main only), `PS_TWO` (main and skid). The skid entry is never valid while main is empty.
- Output decode:
  - `out_valid` = `main_v`.
  - `in_ready` = !`skid_v`.
  - `out_data` = `main_v` ? `main_q` : `NOP_VALUE`.
  - `occupancy` = `main_v` + `skid_v`.
- Transitions when `flush`=0:
  - `PS_EMPTY`, accept: → `PS_ONE`, `main_q`<=`in_data`.
  - `PS_ONE`, accept & drain: stay `PS_ONE`, `main_q`<=`in_data`.
  - `PS_ONE`, accept & !drain: → `PS_TWO`, `skid_q`<=`in_data`.
  - `PS_ONE`, !accept & drain: → `PS_EMPTY`.
  - `PS_ONE`, neither: hold.
  - `PS_TWO`, drain: → `PS_ONE`, `main_q`<=`skid_q`. No accept is possible because `in_ready`=0.
  - `PS_TWO`, no drain: hold.
- Flush has highest priority.
  - Next state is `PS_EMPTY`.
  - An input offered in the flush cycle is dropped, even if `in_ready`=1.
  - A drain in the flush cycle is a completed transfer; downstream keeps it.
  - Data flops need not clear, since `out_data` is masked to `NOP_VALUE`.
- Ordering: strict FIFO. No entry is duplicated, dropped (except by flush) or reordered.
- Stall counter:
  - Increments when `out_valid` & !`out_ready`.
  - Saturates at all-ones and never wraps.
  - `clr_stats` wins over increment: the next value is 0.
  - `flush` does not affect it.
- Reset (async, immediate):
  - Both valids are 0 and the state is `PS_EMPTY`.
  - Outputs: `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, `occupancy`=0, `stall_cycles`=0.
  - Applying reset mid-operation discards all entries with no partial transfer.

## Timing
- Latency: accept in cycle N gives `out_valid`=1 in N+1 with that payload.
- Throughput: one transfer per cycle sustained while `out_ready`=1.
- `in_ready` depends only on flops. There is no combinational path from `out_ready` or `in_valid` to any output.
- `in_ready` deasserts the cycle after the skid entry fills. It reasserts the cycle after a drain or flush from `PS_TWO`.
- Holding rules:
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0, until a flush.
  - Upstream holds `in_data` while `in_valid`=1 and `in_ready`=0.
- `flush` affects outputs in the cycle after it is sampled.

## Structure
- Package `pipe_types`: typedef enum `pipe_state_e` {`PS_EMPTY`, `PS_ONE`, `PS_TWO`}, used for debug decode and assertions.
- Payload structs stay in the existing `ctrl_types`, `instr_types` and `rv32i_types` packages. Each stage packs them into `WIDTH`.
- No sub-module: the two entries plus the counter are inline flops. The existing `register` block is not reused, because its reset is synchronous.
- Assertions:
  - `skid_v` implies `main_v`.
  - No accept while `skid_v`=1.
  - `stall_cycles` is monotonic unless cleared.

## Test plan
- Reset, then accept 0x11 with `out_ready`=1 → cycle+1: `out_valid`=1, `out_data`=0x11, `occupancy`=1. Next cycle `out_data`=`NOP_VALUE`.
- Stream 0x01..0x08 back-to-back with `out_ready`=1 → 0x01..0x08 appear on consecutive cycles, `in_ready` stays 1, `stall_cycles`=0.
- Hold `out_ready`=0 and offer 0xA, 0xB, 0xC → `occupancy`=2, `in_ready`=0, 0xC is held upstream. Then `out_ready`=1 → outputs 0xA, 0xB, 0xC in order; `stall_cycles` equals the number of stalled cycles (3 for the sequence above).
- Stage full with 0xA and 0xB; assert `flush` while offering 0xC → next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, `in_ready`=1. 0xC is never output.
- `CNT_WIDTH`=4 with 20 stalled cycles → `stall_cycles`=15 (saturates). Pulse `clr_stats` during the stall → next value 0.
- Assert `rst` asynchronously mid-clock while holding 2 entries → outputs reach reset values before the next edge. After release, the first accepted payload is the first output.
